// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one fixed-latency data-memory port between the CPU MEM stage and a debug/loader port.
module dmem_arbiter #(
  parameter int MEM_LATENCY = 1,
  parameter int STREAK_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_ack_o,
  output logic        cpu_stall_o,
  input  logic        dbg_req_i,
  input  logic        dbg_we_i,
  input  logic [31:0] dbg_addr_i,
  input  logic [31:0] dbg_wdata_i,
  output logic [31:0] dbg_rdata_o,
  output logic        dbg_ack_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o
);
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int SW = $clog2(STREAK_MAX + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] streak;
  logic owner, we, dbg_win;
  logic [31:0] addr, wdata;
  // debug only wins a contested slot once the CPU has used up its streak
  assign dbg_win = dbg_req_i & (~cpu_req_i | (streak == SW'(STREAK_MAX)));
  assign cpu_stall_o = cpu_req_i & ~cpu_ack_o;
  assign busy_o = state != IDLE;
  assign mem_we_o = (state == ACCESS) & we;
  assign mem_addr_o = addr;
  assign mem_wdata_o = wdata;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      streak <= '0;
      owner <= 1'b0;
      we <= 1'b0;
      addr <= '0;
      wdata <= '0;
      mem_en_o <= 1'b0;
      cpu_ack_o <= 1'b0;
      dbg_ack_o <= 1'b0;
      cpu_rdata_o <= '0;
      dbg_rdata_o <= '0;
    end else begin
      mem_en_o <= 1'b0;
      cpu_ack_o <= 1'b0;
      dbg_ack_o <= 1'b0;
      case (state)
        IDLE: if (cpu_req_i | dbg_req_i) begin
          state <= ACCESS;
          owner <= dbg_win;
          we <= dbg_win ? dbg_we_i : cpu_we_i;
          addr <= dbg_win ? dbg_addr_i : cpu_addr_i;
          wdata <= dbg_win ? dbg_wdata_i : cpu_wdata_i;
          cnt <= CW'(MEM_LATENCY - 1);
          mem_en_o <= 1'b1;
          streak <= (~dbg_win & dbg_req_i) ? streak + 1'b1 : '0;
        end
        ACCESS: if (cnt == '0) begin
          state <= DONE;
          cpu_ack_o <= ~owner;
          dbg_ack_o <= owner;
          if (!we && owner) dbg_rdata_o <= mem_rdata_i;
          if (!we && !owner) cpu_rdata_o <= mem_rdata_i;
        end else cnt <= cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a transaction-level reference model.
module tb_dmem_arbiter;
  localparam int LAT = 3, SMAX = 4;
  logic clk = 0, rst = 0;
  logic cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, dbg_addr = 0, dbg_wdata = 0, mem_rdata = 0;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata;
  logic cpu_ack, cpu_stall, dbg_ack, mem_en, mem_we, busy;
  logic b_req = 0, b_we = 0;
  logic [31:0] b_addr = 0, b_wdata = 0, b_mem_rdata = 0;
  logic [31:0] b_rdata, b_drdata, b_maddr, b_mwdata;
  logic b_ack, b_stall, b_dack, b_en, b_mwe, b_busy;
  int checks = 0, errors = 0;
  int m_t = 0, streak = 0, since = 99;
  bit m_own, m_we, dw;
  logic [31:0] m_addr, m_wdata, paddr = 0, e_crd = 0, e_drd = 0;
  logic [31:0] rmem [64], emem [64];

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_LATENCY(LAT), .STREAK_MAX(SMAX)) dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata), .cpu_ack_o(cpu_ack), .cpu_stall_o(cpu_stall),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_rdata_o(dbg_rdata), .dbg_ack_o(dbg_ack),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .busy_o(busy));

  dmem_arbiter #(.MEM_LATENCY(1), .STREAK_MAX(SMAX)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(b_req), .cpu_we_i(b_we), .cpu_addr_i(b_addr), .cpu_wdata_i(b_wdata),
    .cpu_rdata_o(b_rdata), .cpu_ack_o(b_ack), .cpu_stall_o(b_stall),
    .dbg_req_i(1'b0), .dbg_we_i(1'b0), .dbg_addr_i(32'h0), .dbg_wdata_i(32'h0),
    .dbg_rdata_o(b_drdata), .dbg_ack_o(b_dack),
    .mem_en_o(b_en), .mem_we_o(b_mwe), .mem_addr_o(b_maddr), .mem_wdata_o(b_mwdata),
    .mem_rdata_i(b_mem_rdata), .busy_o(b_busy));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic bit e_cack();
    return m_t == LAT + 1 && !m_own;
  endfunction

  function automatic bit e_dack();
    return m_t == LAT + 1 && m_own;
  endfunction

  // reference model: m_t counts cycles since the grant (0 = idle)
  always @(posedge clk) begin
    if (rst) begin
      m_t = 0; streak = 0; e_crd = 0; e_drd = 0;
    end else if (m_t == 0) begin
      if (cpu_req || dbg_req) begin
        dw = dbg_req && (!cpu_req || streak == SMAX);
        streak = (!dw && dbg_req) ? streak + 1 : 0;
        m_own = dw;
        m_we = dw ? dbg_we : cpu_we;
        m_addr = dw ? dbg_addr : cpu_addr;
        m_wdata = dw ? dbg_wdata : cpu_wdata;
        if (m_we) rmem[m_addr[7:2]] = m_wdata;
        m_t = 1;
      end
    end else begin
      if (m_t == LAT && !m_we) begin
        if (m_own) e_drd = rmem[m_addr[7:2]];
        else e_crd = rmem[m_addr[7:2]];
      end
      m_t = (m_t == LAT + 1) ? 0 : m_t + 1;
    end
    #1;
    if (rst) since = 99;
    else begin
      chk("busy", 32'(busy), 32'(m_t != 0));
      chk("mem_en", 32'(mem_en), 32'(m_t == 1));
      if (m_t >= 1 && m_t <= LAT) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_we", 32'(mem_we), 32'(m_we));
        if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end
      chk("cpu_ack", 32'(cpu_ack), 32'(e_cack()));
      chk("dbg_ack", 32'(dbg_ack), 32'(e_dack()));
      chk("cpu_rdata", cpu_rdata, e_crd);
      chk("dbg_rdata", dbg_rdata, e_drd);
      // memory environment: honours writes and presents read data only at the latency point
      if (mem_en) begin
        since = 0;
        paddr = mem_addr;
        if (mem_we) emem[mem_addr[7:2]] = mem_wdata;
      end else since++;
    end
    mem_rdata = (since == LAT - 1) ? emem[paddr[7:2]] : $urandom;
  end

  always @(negedge clk) begin
    #1;
    if (!rst) chk("stall", 32'(cpu_stall), 32'(cpu_req & ~e_cack()));
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    int got[$];
    for (int i = 0; i < 64; i++) begin
      emem[i] = $urandom;
      rmem[i] = emem[i];
    end
    emem[4] = 32'hDEADBEEF; rmem[4] = 32'hDEADBEEF;
    emem[12] = 32'h0BADF00D; rmem[12] = 32'h0BADF00D;
    #1 rst = 1;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_en", 32'(mem_en), 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_crd", cpu_rdata, 0);
    chk("rst_ack", 32'({cpu_ack, dbg_ack}), 0);
    chk("rst_b", 32'({b_busy, b_en, b_ack}), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;

    // single-cycle latency instance: read then write
    b_mem_rdata = 32'hA5A51234;
    @(negedge clk); b_req = 1; b_we = 0; b_addr = 32'h20;
    tick();
    chk("b_en_rd", 32'(b_en), 1);
    chk("b_ack_early", 32'(b_ack), 0);
    tick();
    chk("b_ack_rd", 32'(b_ack), 1);
    chk("b_rdata", b_rdata, 32'hA5A51234);
    @(negedge clk); b_req = 0;
    @(negedge clk); b_req = 1; b_we = 1; b_wdata = 32'h12345678; b_mem_rdata = 32'h11111111;
    tick();
    chk("b_en_wr", 32'(b_en), 1);
    chk("b_we", 32'(b_mwe), 1);
    chk("b_maddr", b_maddr, 32'h20);
    chk("b_mwdata", b_mwdata, 32'h12345678);
    tick();
    chk("b_ack_wr", 32'(b_ack), 1);
    chk("b_rdata_keep", b_rdata, 32'hA5A51234);
    @(negedge clk); b_req = 0;

    // CPU read with address change mid-access, debug request arriving during ACCESS
    @(negedge clk); cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    #1 chk("stall_c0", 32'(cpu_stall), 1);
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c <= 5) chk("en_a", 32'(mem_en), 32'(c == 1));
      if (c <= 3) begin
        chk("addr_hold", mem_addr, 32'h10);
        chk("stall_a", 32'(cpu_stall), 1);
      end
      chk("cack_a", 32'(cpu_ack), 32'(c == 4));
      chk("dack_a", 32'(dbg_ack), 32'(c == 9));
      if (c == 4) begin
        chk("crd_a", cpu_rdata, 32'hDEADBEEF);
        chk("stall_ackcyc", 32'(cpu_stall), 0);
      end
      if (c >= 5) chk("crd_keep", cpu_rdata, 32'hDEADBEEF);
      if (c == 9) chk("drd_a", dbg_rdata, 32'h0BADF00D);
      @(negedge clk);
      if (c == 2) begin
        cpu_addr = 32'h44; dbg_req = 1; dbg_we = 0; dbg_addr = 32'h30;
      end
      if (c == 4) cpu_req = 0;
      if (c == 9) dbg_req = 0;
    end

    // reset in the middle of an access
    @(negedge clk); cpu_req = 1; cpu_addr = 32'h08;
    tick();
    @(posedge clk);
    @(negedge clk); rst = 1; cpu_req = 0;
    #1;
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_en", 32'({mem_en, mem_we}), 0);
    chk("mrst_addr", mem_addr, 0);
    chk("mrst_wdata", mem_wdata, 0);
    chk("mrst_rdata", cpu_rdata | dbg_rdata, 0);
    chk("mrst_ack", 32'({cpu_ack, dbg_ack}), 0);
    @(negedge clk) rst = 0;
    repeat (5) begin
      tick();
      chk("no_ack_after_rst", 32'(cpu_ack), 0);
    end
    @(negedge clk); cpu_req = 1; cpu_addr = 32'h10;
    n = 0;
    do begin
      tick();
      n++;
    end while (!cpu_ack && n < 10);
    chk("post_rst_lat", 32'(n), 32'(LAT + 1));
    chk("post_rst_rd", cpu_rdata, 32'hDEADBEEF);
    @(negedge clk); cpu_req = 0;

    // both ports requesting continuously from a fresh reset
    @(negedge clk) rst = 1;
    @(negedge clk) rst = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h50;
    for (int i = 0; i < 200 && got.size() < 10; i++) begin
      tick();
      if (cpu_ack) got.push_back(0);
      if (dbg_ack) got.push_back(1);
    end
    chk("grant_count", 32'(got.size()), 10);
    foreach (got[i]) chk("grant_order", 32'(got[i]), 32'(i % 5 == 4));
    @(negedge clk); cpu_req = 0; dbg_req = 0;

    // randomized traffic; fields only move while that port's access is in flight
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cpu_req && e_cack()) cpu_req = 0;
      if (dbg_req && e_dack()) dbg_req = 0;
      if (!cpu_req) begin
        if ($urandom_range(0, 2) == 0) begin
          cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
          cpu_addr = $urandom_range(0, 63) << 2; cpu_wdata = $urandom;
        end
      end else if (m_t >= 1 && m_t <= LAT && !m_own && $urandom_range(0, 3) == 0) begin
        cpu_we = 1'($urandom_range(0, 1)); cpu_addr = $urandom_range(0, 63) << 2; cpu_wdata = $urandom;
      end
      if (!dbg_req) begin
        if ($urandom_range(0, 3) == 0) begin
          dbg_req = 1; dbg_we = 1'($urandom_range(0, 1));
          dbg_addr = $urandom_range(0, 63) << 2; dbg_wdata = $urandom;
        end
      end else if (m_t >= 1 && m_t <= LAT && m_own && $urandom_range(0, 3) == 0) begin
        dbg_we = 1'($urandom_range(0, 1)); dbg_addr = $urandom_range(0, 63) << 2; dbg_wdata = $urandom;
      end
    end
    for (int i = 0; i < 100 && (cpu_req || dbg_req || m_t != 0); i++) begin
      @(negedge clk);
      if (cpu_req && e_cack()) cpu_req = 0;
      if (dbg_req && e_dack()) dbg_req = 0;
    end
    chk("drain", 32'({cpu_req, dbg_req}), 0);
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
